// File: rtl/prm_occ_frame_loader_if.sv
// Handshake bundle between the voxel-index producer, the frame loader and the result consumer.
// The master side drives the voxel beats and the result acknowledge. The slave side is the loader.
interface prm_occ_frame_loader_if #(
  parameter int IDX_W = 4,
  parameter int CNT_W = 5
);
  logic             vox_valid;
  logic             vox_ready;
  logic [IDX_W-1:0] vox_idx;
  logic             vox_last;
  logic             res_valid;
  logic             res_ready;
  logic             res_blocked;
  logic [CNT_W-1:0] res_count;
  logic             res_err;

  modport master (
    output vox_valid, vox_idx, vox_last, res_ready,
    input  vox_ready, res_valid, res_blocked, res_count, res_err
  );

  modport slave (
    input  vox_valid, vox_idx, vox_last, res_ready,
    output vox_ready, res_valid, res_blocked, res_count, res_err
  );
endinterface

// File: rtl/prm_occ_frame_loader.sv
// Builds one obstacle frame of voxel indices into a shadow vector and commits it atomically to the checker inputs.
// After a settle window it samples the checker's edge_mask and reports it as a single result beat.
module prm_occ_frame_loader #(
  parameter int NUM_VOX    = 15,
  parameter int IDX_W      = 4,
  parameter int CNT_W      = 5,
  parameter int SETTLE_CYC = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  prm_occ_frame_loader_if.slave  bus,
  output logic [NUM_VOX-1:0]     occ_vec,
  input  logic                   edge_mask_in,
  output logic                   busy
);

  localparam int SET_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

  typedef enum logic [1:0] {
    S_LOAD   = 2'd0,
    S_SETTLE = 2'd1,
    S_REPORT = 2'd2
  } state_e;

  state_e             state_q,       state_d;
  logic [NUM_VOX-1:0] shadow_q,      shadow_d;
  logic [NUM_VOX-1:0] occ_q,         occ_d;
  logic [CNT_W-1:0]   beat_cnt_q,    beat_cnt_d;
  logic               err_q,         err_d;
  logic [SET_W-1:0]   settle_q,      settle_d;
  logic               res_valid_q,   res_valid_d;
  logic               res_blocked_q, res_blocked_d;
  logic [CNT_W-1:0]   res_count_q,   res_count_d;
  logic               res_err_q,     res_err_d;

  logic               beat_fire;
  logic               idx_ok;
  logic [NUM_VOX-1:0] beat_bit;
  logic [CNT_W-1:0]   beat_cnt_inc;

  // Ready is gated by rst_n so no beat can be claimed while the loader is held in reset.
  assign bus.vox_ready = rst_n && (state_q == S_LOAD);
  assign beat_fire     = bus.vox_valid && bus.vox_ready;
  assign idx_ok        = {1'b0, bus.vox_idx} < (IDX_W + 1)'(NUM_VOX);
  assign beat_bit      = idx_ok ? (NUM_VOX'(1) << bus.vox_idx) : '0;
  assign beat_cnt_inc  = (beat_cnt_q == '1) ? beat_cnt_q : beat_cnt_q + CNT_W'(1);

  // NOTE: every signal written here gets a default first, so no path through the case can infer a latch.
  always_comb begin
    state_d       = state_q;
    shadow_d      = shadow_q;
    occ_d         = occ_q;
    beat_cnt_d    = beat_cnt_q;
    err_d         = err_q;
    settle_d      = settle_q;
    res_valid_d   = res_valid_q;
    res_blocked_d = res_blocked_q;
    res_count_d   = res_count_q;
    res_err_d     = res_err_q;

    unique case (state_q)
      S_LOAD: begin
        if (beat_fire) begin
          beat_cnt_d = beat_cnt_inc;
          err_d      = err_q || !idx_ok;
          if (bus.vox_last) begin
            occ_d    = shadow_q | beat_bit;
            shadow_d = '0;
            settle_d = SET_W'(SETTLE_CYC - 1);
            state_d  = S_SETTLE;
          end else begin
            shadow_d = shadow_q | beat_bit;
          end
        end
      end
      S_SETTLE: begin
        if (settle_q == '0) begin
          res_blocked_d = edge_mask_in;
          res_count_d   = beat_cnt_q;
          res_err_d     = err_q;
          res_valid_d   = 1'b1;
          beat_cnt_d    = '0;
          err_d         = 1'b0;
          state_d       = S_REPORT;
        end else begin
          settle_d = settle_q - SET_W'(1);
        end
      end
      S_REPORT: begin
        if (bus.res_ready) begin
          res_valid_d = 1'b0;
          state_d     = S_LOAD;
        end
      end
      default: state_d = S_LOAD;
    endcase
  end

  // NOTE: state updates use non-blocking assignments so every register samples pre-edge values.
  // NOTE: the shadow vector is reset along with the control state; a reset must discard any half-built frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_LOAD;
      shadow_q      <= '0;
      occ_q         <= '0;
      beat_cnt_q    <= '0;
      err_q         <= 1'b0;
      settle_q      <= '0;
      res_valid_q   <= 1'b0;
      res_blocked_q <= 1'b0;
      res_count_q   <= '0;
      res_err_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      shadow_q      <= shadow_d;
      occ_q         <= occ_d;
      beat_cnt_q    <= beat_cnt_d;
      err_q         <= err_d;
      settle_q      <= settle_d;
      res_valid_q   <= res_valid_d;
      res_blocked_q <= res_blocked_d;
      res_count_q   <= res_count_d;
      res_err_q     <= res_err_d;
    end
  end

  assign occ_vec         = occ_q;
  assign busy            = (state_q == S_SETTLE) || (state_q == S_REPORT);
  assign bus.res_valid   = res_valid_q;
  assign bus.res_blocked = res_blocked_q;
  assign bus.res_count   = res_count_q;
  assign bus.res_err     = res_err_q;

endmodule
